// File: rtl/lsu_bus_splitter_pkg.sv
// Shared types for the load/store bus splitter: memory op encodings, FSM states,
// latched request payload and the access-size helper.
package lsu_bus_splitter_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned SIZE_W = 3;

   typedef enum logic [2:0] {
      RD_NONE   = 3'd0,
      RD_BYTE   = 3'd1,
      RD_HALF   = 3'd2,
      RD_WORD   = 3'd3,
      RD_BYTE_U = 3'd4,
      RD_HALF_U = 3'd5
   } mem_read_t;

   typedef enum logic [1:0] {
      WR_NONE = 2'd0,
      WR_BYTE = 2'd1,
      WR_HALF = 2'd2,
      WR_WORD = 2'd3
   } mem_write_t;

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, DONE} lsu_state_t;

   typedef struct packed {
      mem_read_t           rd;
      mem_write_t          wr;
      logic [WORD_W-1:0]   wdata;
   } req_op_t;

   // Bytes touched by the access; a read encoding takes precedence over a write.
   function automatic logic [SIZE_W-1:0] access_size(input mem_read_t rd, input mem_write_t wr);
      logic [SIZE_W-1:0] sz;
      sz = 3'd0;
      case (rd)
         RD_BYTE, RD_BYTE_U: sz = 3'd1;
         RD_HALF, RD_HALF_U: sz = 3'd2;
         RD_WORD:            sz = 3'd4;
         default: begin
            case (wr)
               WR_BYTE: sz = 3'd1;
               WR_HALF: sz = 3'd2;
               WR_WORD: sz = 3'd4;
               default: sz = 3'd0;
            endcase
         end
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/lsu_bus_splitter_if.sv
// Request/response and data-bus signals of the load/store splitter.
interface lsu_bus_splitter_if #(
   parameter int unsigned BUS_BYTES = 4,
   parameter int unsigned ADDR_W    = 32
);
   import lsu_bus_splitter_pkg::*;

   logic                     req_valid;
   logic                     req_ready;
   logic [ADDR_W-1:0]        req_addr;
   logic [WORD_W-1:0]        req_wdata;
   logic [2:0]               req_read;
   logic [1:0]               req_write;
   logic                     rsp_valid;
   logic [WORD_W-1:0]        rsp_rdata;
   logic                     rsp_fault;
   logic                     bus_valid;
   logic                     bus_ready;
   logic [ADDR_W-1:0]        bus_addr;
   logic                     bus_we;
   logic [BUS_BYTES-1:0]     bus_wstrb;
   logic [8*BUS_BYTES-1:0]   bus_wdata;
   logic                     bus_rvalid;
   logic [8*BUS_BYTES-1:0]   bus_rdata;

   modport slave (
      input  req_valid, req_addr, req_wdata, req_read, req_write,
             bus_ready, bus_rvalid, bus_rdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault,
             bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata
   );

   modport master (
      output req_valid, req_addr, req_wdata, req_read, req_write,
             bus_ready, bus_rvalid, bus_rdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault,
             bus_valid, bus_addr, bus_we, bus_wstrb, bus_wdata
   );

endinterface

// File: rtl/lsu_bus_splitter_lane_align.sv
// Combinational lane steering: strobe/store-data shift across two beats, and
// little-endian merge plus sign/zero extension of load data.
module lsu_bus_splitter_lane_align
   import lsu_bus_splitter_pkg::*;
#(
   parameter  int unsigned BUS_BYTES = 4,
   localparam int unsigned OFF_W     = $clog2(BUS_BYTES),
   localparam int unsigned BUS_W     = 8 * BUS_BYTES
) (
   input  logic [OFF_W-1:0]      offset,
   input  logic [SIZE_W-1:0]     size,
   input  logic [WORD_W-1:0]     wdata,
   input  mem_read_t             rd,
   input  logic [BUS_W-1:0]      beat0,
   input  logic [BUS_W-1:0]      beat1,
   output logic                  split_c,
   output logic [BUS_BYTES-1:0]  strb0_c,
   output logic [BUS_BYTES-1:0]  strb1_c,
   output logic [BUS_W-1:0]      wdata0_c,
   output logic [BUS_W-1:0]      wdata1_c,
   output logic [WORD_W-1:0]     rdata_c
);
   localparam int unsigned STRB_W = 2 * BUS_BYTES;
   localparam int unsigned WIDE_W = 2 * BUS_W;

   logic [STRB_W-1:0] strb_wide;
   logic [WIDE_W-1:0] wdata_wide;
   logic [WORD_W-1:0] merged;

   always_comb begin
      split_c    = (5'(offset) + 5'(size)) > 5'(BUS_BYTES);
      strb_wide  = STRB_W'((32'd1 << size) - 32'd1) << offset;
      wdata_wide = WIDE_W'(wdata) << {offset, 3'b000};
      merged     = WORD_W'({beat1, beat0} >> {offset, 3'b000});
      strb0_c    = strb_wide[BUS_BYTES-1:0];
      strb1_c    = strb_wide[STRB_W-1:BUS_BYTES];
      wdata0_c   = wdata_wide[BUS_W-1:0];
      wdata1_c   = wdata_wide[WIDE_W-1:BUS_W];
      case (rd)
         RD_BYTE:   rdata_c = {{24{merged[7]}}, merged[7:0]};
         RD_HALF:   rdata_c = {{16{merged[15]}}, merged[15:0]};
         RD_BYTE_U: rdata_c = {24'd0, merged[7:0]};
         RD_HALF_U: rdata_c = {16'd0, merged[15:0]};
         default:   rdata_c = merged;
      endcase
   end

endmodule

// File: rtl/lsu_bus_splitter.sv
// Load/store unit front end: latches one request, issues one or two bus beats,
// and returns merged/extended load data with a single-cycle completion pulse.
module lsu_bus_splitter
   import lsu_bus_splitter_pkg::*;
#(
   parameter int unsigned BUS_BYTES        = 4,
   parameter int unsigned ADDR_W           = 32,
   parameter bit          ALLOW_MISALIGNED = 1'b1
) (
   input logic               clk,
   input logic               rst_n,
   lsu_bus_splitter_if.slave bif
);
   localparam int unsigned OFF_W = $clog2(BUS_BYTES);
   localparam int unsigned BUS_W = 8 * BUS_BYTES;

   lsu_state_t           state, state_n;
   logic [ADDR_W-1:0]    addr_q;
   req_op_t              op_q;
   logic [BUS_W-1:0]     beat0_q;

   logic [ADDR_W-1:0]    cur_addr, base_addr, beat1_addr;
   req_op_t              cur_op;
   logic [SIZE_W-1:0]    cur_size;
   logic                 cur_rd, cur_wr, misaligned, cur_fault;
   logic [BUS_W-1:0]     merge_b0;
   logic                 split_c;
   logic [BUS_BYTES-1:0] strb0_c, strb1_c;
   logic [BUS_W-1:0]     wdata0_c, wdata1_c;
   logic [WORD_W-1:0]    rdata_c;

   // Live request while idle (decided on the accept edge), latched copy afterwards
   always_comb begin
      cur_addr = addr_q;
      cur_op   = op_q;
      if (state == IDLE) begin
         cur_addr     = bif.req_addr;
         cur_op.rd    = mem_read_t'(bif.req_read);
         cur_op.wr    = mem_write_t'(bif.req_write);
         cur_op.wdata = bif.req_wdata;
      end
      cur_size   = access_size(cur_op.rd, cur_op.wr);
      cur_rd     = access_size(cur_op.rd, WR_NONE) != 3'd0;
      cur_wr     = cur_op.wr != WR_NONE;
      misaligned = (cur_size != 3'd0) && ((cur_addr[1:0] & 2'(cur_size - 3'd1)) != 2'b00);
      cur_fault  = (cur_rd && cur_wr) || (!ALLOW_MISALIGNED && misaligned);
      base_addr  = cur_addr & ~ADDR_W'(BUS_BYTES - 1);
      beat1_addr = base_addr + ADDR_W'(BUS_BYTES);
      merge_b0   = (state == WAIT0) ? bif.bus_rdata : beat0_q;
   end

   lsu_bus_splitter_lane_align #(.BUS_BYTES(BUS_BYTES)) u_align (
      .offset   (cur_addr[OFF_W-1:0]),
      .size     (cur_size),
      .wdata    (cur_op.wdata),
      .rd       (cur_op.rd),
      .beat0    (merge_b0),
      .beat1    (bif.bus_rdata),
      .split_c  (split_c),
      .strb0_c  (strb0_c),
      .strb1_c  (strb1_c),
      .wdata0_c (wdata0_c),
      .wdata1_c (wdata1_c),
      .rdata_c  (rdata_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:  if (bif.req_valid)
                   state_n = (cur_fault || (!cur_rd && !cur_wr)) ? DONE : REQ0;
         REQ0:  if (bif.bus_ready)
                   state_n = cur_wr ? (split_c ? REQ1 : DONE) : WAIT0;
         WAIT0: if (bif.bus_rvalid)
                   state_n = split_c ? REQ1 : DONE;
         REQ1:  if (bif.bus_ready)
                   state_n = cur_wr ? DONE : WAIT1;
         WAIT1: if (bif.bus_rvalid)
                   state_n = DONE;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Request latch and first-beat read capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         op_q    <= '{rd: RD_NONE, wr: WR_NONE, wdata: '0};
         beat0_q <= '0;
      end else begin
         if (state == IDLE && bif.req_valid) begin
            addr_q <= cur_addr;
            op_q   <= cur_op;
         end
         if (state == WAIT0 && bif.bus_rvalid) beat0_q <= bif.bus_rdata;
      end
   end

   // Outputs registered from the next state so they line up with the state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bif.req_ready <= 1'b1;
         bif.rsp_valid <= 1'b0;
         bif.rsp_rdata <= '0;
         bif.rsp_fault <= 1'b0;
         bif.bus_valid <= 1'b0;
         bif.bus_addr  <= '0;
         bif.bus_we    <= 1'b0;
         bif.bus_wstrb <= '0;
         bif.bus_wdata <= '0;
      end else begin
         bif.req_ready <= (state_n == IDLE);
         bif.rsp_valid <= (state_n == DONE);
         bif.rsp_fault <= (state_n == DONE) && (state == IDLE) && cur_fault;
         if (state_n == DONE)
            bif.rsp_rdata <= (state == WAIT0 || state == WAIT1) ? rdata_c : '0;
         bif.bus_valid <= (state_n == REQ0) || (state_n == REQ1);
         bif.bus_we    <= ((state_n == REQ0) || (state_n == REQ1)) && cur_wr;
         if (state_n == REQ1) begin
            bif.bus_addr  <= beat1_addr;
            bif.bus_wstrb <= strb1_c;
            bif.bus_wdata <= cur_wr ? wdata1_c : '0;
         end else if (state_n == REQ0) begin
            bif.bus_addr  <= base_addr;
            bif.bus_wstrb <= strb0_c;
            bif.bus_wdata <= cur_wr ? wdata0_c : '0;
         end else begin
            bif.bus_addr  <= '0;
            bif.bus_wstrb <= '0;
            bif.bus_wdata <= '0;
         end
      end
   end

endmodule

// File: tb/tb_lsu_bus_splitter.sv
// Directed bench: vector table of single transactions on a misaligned-capable
// instance, plus hand sequences for hold/reset and an aligned-only instance.
module tb_lsu_bus_splitter;
   import lsu_bus_splitter_pkg::*;

   typedef struct {
      mem_read_t   rd;
      mem_write_t  wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] d0;
      logic [31:0] d1;
      int          lat;
      logic [31:0] rdata;
      logic        fault;
      int          nbeats;
      logic [31:0] a0;
      logic [3:0]  s0;
      logic [31:0] w0;
      logic [31:0] a1;
      logic [3:0]  s1;
      logic [31:0] w1;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } beat_t;

   logic        clk;
   logic        rst_n;
   int          checks = 0;
   int          errors = 0;
   beat_t       beats[$];
   logic [31:0] rdq[$];
   int          bv1_cnt = 0;
   beat_t       last1;
   vec_t        vecs[14];

   lsu_bus_splitter_if #(.BUS_BYTES(4), .ADDR_W(32)) if0 ();
   lsu_bus_splitter_if #(.BUS_BYTES(4), .ADDR_W(32)) if1 ();

   lsu_bus_splitter #(.BUS_BYTES(4), .ADDR_W(32), .ALLOW_MISALIGNED(1'b1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bif(if0));
   lsu_bus_splitter #(.BUS_BYTES(4), .ADDR_W(32), .ALLOW_MISALIGNED(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .bif(if1));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Zero-wait bus for dut0: log each handshake, answer reads one cycle later
   initial begin
      bit    hs;
      beat_t b;
      if0.bus_rvalid = 1'b0;
      if0.bus_rdata  = 32'h0;
      forever begin
         @(negedge clk);
         hs = (rst_n === 1'b1) && if0.bus_valid && if0.bus_ready;
         b  = '{if0.bus_addr, if0.bus_we, if0.bus_wstrb, if0.bus_wdata};
         if (hs) beats.push_back(b);
         @(posedge clk);
         #1;
         if (hs && !b.we) begin
            if0.bus_rvalid = 1'b1;
            if0.bus_rdata  = (rdq.size() > 0) ? rdq.pop_front() : 32'hDEADBEEF;
         end else begin
            if0.bus_rvalid = 1'b0;
         end
      end
   end

   // Beat monitor for the aligned-only instance
   initial begin
      forever begin
         @(negedge clk);
         if (if1.bus_valid) begin
            bv1_cnt++;
            last1 = '{if1.bus_addr, if1.bus_we, if1.bus_wstrb, if1.bus_wdata};
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // One request; lat = cycle (after the accept edge) in which rsp_valid is seen, -1 on timeout
   task automatic do_req(input bit sel, input mem_read_t rd, input mem_write_t wr,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rdata, output logic fault);
      bit got;
      int n;
      @(posedge clk);
      #1;
      if (sel) begin
         if1.req_valid = 1'b1; if1.req_read = rd; if1.req_write = wr;
         if1.req_addr  = addr; if1.req_wdata = wd;
      end else begin
         if0.req_valid = 1'b1; if0.req_read = rd; if0.req_write = wr;
         if0.req_addr  = addr; if0.req_wdata = wd;
      end
      @(posedge clk);
      #1;
      if0.req_valid = 1'b0;
      if1.req_valid = 1'b0;
      got = 1'b0;
      n   = 0;
      while (!got && n < 40) begin
         @(negedge clk);
         n++;
         got = sel ? if1.rsp_valid : if0.rsp_valid;
      end
      lat   = got ? n : -1;
      rdata = sel ? if1.rsp_rdata : if0.rsp_rdata;
      fault = sel ? if1.rsp_fault : if0.rsp_fault;
   endtask

   initial begin
      int          lat;
      logic [31:0] rdata;
      logic        fault;
      int          bv_before;

      rst_n = 1'b0;
      if0.req_valid = 1'b0; if0.req_addr = '0; if0.req_wdata = '0;
      if0.req_read  = 3'd0; if0.req_write = 2'd0; if0.bus_ready = 1'b1;
      if1.req_valid = 1'b0; if1.req_addr = '0; if1.req_wdata = '0;
      if1.req_read  = 3'd0; if1.req_write = 2'd0; if1.bus_ready = 1'b1;
      if1.bus_rvalid = 1'b0; if1.bus_rdata = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_req_ready", 32'(if0.req_ready), 32'd1);
      chk("reset_rsp_valid", 32'(if0.rsp_valid), 32'd0);
      chk("reset_bus_valid", 32'(if0.bus_valid), 32'd0);
      chk("reset_rsp_rdata", if0.rsp_rdata, 32'd0);
      chk("reset_bus_wstrb", 32'(if0.bus_wstrb), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      vecs[0]  = '{RD_WORD,   WR_NONE, 32'h00001004, 32'h0, 32'h11223344, 32'h0, 3, 32'h11223344, 1'b0, 1, 32'h00001004, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vecs[1]  = '{RD_BYTE,   WR_NONE, 32'h00001003, 32'h0, 32'h80000000, 32'h0, 3, 32'hFFFFFF80, 1'b0, 1, 32'h00001000, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vecs[2]  = '{RD_BYTE_U, WR_NONE, 32'h00001003, 32'h0, 32'h80000000, 32'h0, 3, 32'h00000080, 1'b0, 1, 32'h00001000, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vecs[3]  = '{RD_NONE,   WR_HALF, 32'h00001002, 32'h0000ABCD, 32'h0, 32'h0, 2, 32'h0, 1'b0, 1, 32'h00001000, 4'b1100, 32'hABCD0000, 32'h0, 4'h0, 32'h0};
      vecs[4]  = '{RD_WORD,   WR_NONE, 32'h00001006, 32'h0, 32'h5566AAAA, 32'hBBBB7788, 5, 32'h77885566, 1'b0, 2, 32'h00001004, 4'h0, 32'h0, 32'h00001008, 4'h0, 32'h0};
      vecs[5]  = '{RD_NONE,   WR_WORD, 32'h00001006, 32'h11223344, 32'h0, 32'h0, 3, 32'h0, 1'b0, 2, 32'h00001004, 4'b1100, 32'h33440000, 32'h00001008, 4'b0011, 32'h00001122};
      vecs[6]  = '{RD_HALF,   WR_NONE, 32'h00001003, 32'h0, 32'h80AAAAAA, 32'hBBBBBBFF, 5, 32'hFFFFFF80, 1'b0, 2, 32'h00001000, 4'h0, 32'h0, 32'h00001004, 4'h0, 32'h0};
      vecs[7]  = '{RD_HALF_U, WR_NONE, 32'h00001002, 32'h0, 32'h80011234, 32'h0, 3, 32'h00008001, 1'b0, 1, 32'h00001000, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vecs[8]  = '{RD_NONE,   WR_BYTE, 32'h00001001, 32'h000000A5, 32'h0, 32'h0, 2, 32'h0, 1'b0, 1, 32'h00001000, 4'b0010, 32'h0000A500, 32'h0, 4'h0, 32'h0};
      vecs[9]  = '{RD_WORD,   WR_NONE, 32'hFFFFFFFE, 32'h0, 32'h2211CCCC, 32'hDDDD4433, 5, 32'h44332211, 1'b0, 2, 32'hFFFFFFFC, 4'h0, 32'h0, 32'h00000000, 4'h0, 32'h0};
      vecs[10] = '{RD_WORD,   WR_WORD, 32'h00001000, 32'h12345678, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vecs[11] = '{RD_NONE,   WR_NONE, 32'h00001000, 32'h0, 32'h0, 32'h0, 1, 32'h0, 1'b0, 0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vecs[12] = '{RD_HALF,   WR_NONE, 32'h00001001, 32'h0, 32'h00BEEF00, 32'h0, 3, 32'hFFFFBEEF, 1'b0, 1, 32'h00001000, 4'h0, 32'h0, 32'h0, 4'h0, 32'h0};
      vecs[13] = '{RD_NONE,   WR_HALF, 32'h00001003, 32'h0000BEEF, 32'h0, 32'h0, 3, 32'h0, 1'b0, 2, 32'h00001000, 4'b1000, 32'hEF000000, 32'h00001004, 4'b0001, 32'h000000BE};

      foreach (vecs[i]) begin
         beats.delete();
         rdq.delete();
         rdq.push_back(vecs[i].d0);
         rdq.push_back(vecs[i].d1);
         do_req(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, rdata, fault);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
         chk($sformatf("v%0d_fault", i), 32'(fault), 32'(vecs[i].fault));
         chk($sformatf("v%0d_nbeats", i), 32'(beats.size()), 32'(vecs[i].nbeats));
         if (vecs[i].nbeats >= 1 && beats.size() >= 1) begin
            chk($sformatf("v%0d_b0_addr", i), beats[0].addr, vecs[i].a0);
            chk($sformatf("v%0d_b0_we", i), 32'(beats[0].we), 32'(vecs[i].wr != WR_NONE));
            if (vecs[i].wr != WR_NONE) begin
               chk($sformatf("v%0d_b0_strb", i), 32'(beats[0].strb), 32'(vecs[i].s0));
               chk($sformatf("v%0d_b0_wdata", i), beats[0].wdata, vecs[i].w0);
            end
         end
         if (vecs[i].nbeats == 2 && beats.size() >= 2) begin
            chk($sformatf("v%0d_b1_addr", i), beats[1].addr, vecs[i].a1);
            if (vecs[i].wr != WR_NONE) begin
               chk($sformatf("v%0d_b1_strb", i), 32'(beats[1].strb), 32'(vecs[i].s1));
               chk($sformatf("v%0d_b1_wdata", i), beats[1].wdata, vecs[i].w1);
            end
         end
      end

      // Load data held after the one-cycle pulse
      rdq.delete();
      rdq.push_back(32'h600DF00D);
      do_req(1'b0, RD_WORD, WR_NONE, 32'h00003000, 32'h0, lat, rdata, fault);
      chk("hold_lat", 32'(lat), 32'd3);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("pulse_rsp_valid_%0d", k), 32'(if0.rsp_valid), 32'd0);
         chk($sformatf("held_rdata_%0d", k), if0.rsp_rdata, 32'h600DF00D);
         chk($sformatf("idle_req_ready_%0d", k), 32'(if0.req_ready), 32'd1);
      end

      // Stalled beat stays stable, then reset abandons it
      if0.bus_ready = 1'b0;
      @(posedge clk);
      #1;
      if0.req_valid = 1'b1; if0.req_read = RD_WORD; if0.req_write = WR_NONE;
      if0.req_addr = 32'h00002000;
      @(posedge clk);
      #1;
      if0.req_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("stall_bus_valid_%0d", k), 32'(if0.bus_valid), 32'd1);
         chk($sformatf("stall_bus_addr_%0d", k), if0.bus_addr, 32'h00002000);
         chk($sformatf("stall_req_ready_%0d", k), 32'(if0.req_ready), 32'd0);
      end
      #2 rst_n = 1'b0;
      #1;
      chk("rst_bus_valid", 32'(if0.bus_valid), 32'd0);
      chk("rst_req_ready", 32'(if0.req_ready), 32'd1);
      chk("rst_rsp_rdata", if0.rsp_rdata, 32'd0);
      chk("rst_bus_addr", if0.bus_addr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      if0.bus_ready = 1'b1;
      beats.delete();
      rdq.delete();
      rdq.push_back(32'hCAFEF00D);
      do_req(1'b0, RD_WORD, WR_NONE, 32'h00002000, 32'h0, lat, rdata, fault);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_rdata", rdata, 32'hCAFEF00D);
      chk("post_rst_nbeats", 32'(beats.size()), 32'd1);

      // Aligned-only instance
      bv_before = bv1_cnt;
      do_req(1'b1, RD_HALF, WR_NONE, 32'h00001001, 32'h0, lat, rdata, fault);
      chk("al_lh_lat", 32'(lat), 32'd1);
      chk("al_lh_fault", 32'(fault), 32'd1);
      chk("al_lh_rdata", rdata, 32'd0);
      do_req(1'b1, RD_NONE, WR_HALF, 32'h00001003, 32'h0000BEEF, lat, rdata, fault);
      chk("al_sh_fault", 32'(fault), 32'd1);
      do_req(1'b1, RD_WORD, WR_NONE, 32'h00001006, 32'h0, lat, rdata, fault);
      chk("al_lw_fault", 32'(fault), 32'd1);
      chk("al_no_bus_valid", 32'(bv1_cnt), 32'(bv_before));
      do_req(1'b1, RD_NONE, WR_WORD, 32'h00001004, 32'h12345678, lat, rdata, fault);
      chk("al_sw_lat", 32'(lat), 32'd2);
      chk("al_sw_fault", 32'(fault), 32'd0);
      chk("al_sw_beats", 32'(bv1_cnt), 32'(bv_before + 1));
      chk("al_sw_addr", last1.addr, 32'h00001004);
      chk("al_sw_we", 32'(last1.we), 32'd1);
      chk("al_sw_strb", 32'(last1.strb), 32'hF);
      chk("al_sw_wdata", last1.wdata, 32'h12345678);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
